logic_pipe_scoreboard: RTL
==========================

# logic_pipe_scoreboard

Receiving-end checker for the pipelined logic-operation datapath. Captures each 32-bit operand word issued to the producer, pairs it in order with the producer's returned 8-bit E/F results, recomputes the expected values and reports match/mismatch with saturating counts and sticky error flags. Sits beside the producer in simulation benches and on-chip self-test, consuming its output stream.

## Interface
- DEPTH, 8, operand FIFO depth; power of 2, ≥2
- CNT_W, 16, width of pass/fail counters
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear; same effect as rst, next edge
- in_valid  in  1  operand word issued to producer this cycle
- in_word  in  32  operand: A=[7:0], B=[15:8], C=[23:16], D=[31:24]
- in_ready  out  1  FIFO can accept a word
- res_valid  in  1  producer result valid this cycle
- res_e  in  8  returned E
- res_f  in  8  returned F
- match_pulse  out  1  one-cycle pulse: compared result correct
- mismatch_pulse  out  1  one-cycle pulse: compared result wrong
- pass_count  out  CNT_W  saturating count of matches
- fail_count  out  CNT_W  saturating count of mismatches
- first_fail_word  out  32  operand of first mismatch
- first_fail_got  out  16  {res_e,res_f} of first mismatch
- overflow_err  out  1  sticky: in_valid while full
- underflow_err  out  1  sticky: res_valid while empty
- pending  out  $clog2(DEPTH)+1  words held in FIFO

## Operation
- Expected: E = A | (B & C); F = (B & C) ^ (A | D); all 8-bit bitwise, no carries.
- Push: in_valid & in_ready writes in_word at tail. in_ready = !full (no bypass).
- in_valid & full: word dropped, overflow_err set, FIFO unchanged.
- Pop: res_valid & !empty (state at that edge) pops head; expected computed from head word.
- res_valid & empty: result discarded, underflow_err set, no pulse, counts unchanged; a simultaneous push still completes.
- Simultaneous push and pop when neither full nor empty: pending unchanged, order preserved.
- Compare stage: popped word, res_e, res_f registered; next cycle exactly one of match_pulse/mismatch_pulse asserted.
- Counters increment with their pulse; hold at 2^CNT_W-1.
- first_fail_word/first_fail_got load on first mismatch only (fail_count was 0), then hold.
- Pointers wrap modulo DEPTH; pending distinguishes full (DEPTH) from empty (0).
- rst or clear: FIFO emptied, all outputs 0, in_ready=1; in-flight compare discarded (no pulse after). clear wins over simultaneous push/pop.

## Timing
- Reset values: in_ready=1, all other outputs 0.
- pending, in_ready update at the edge sampling the handshake; visible next cycle.
- Result latency: res_valid at edge N -> pulse and counter update visible after edge N+1 (one cycle).
- Back-to-back res_valid every cycle supported; one pulse per cycle, no stalls.
- Sticky flags set after sampling edge; cleared only by rst/clear.
- Full throughput: one push and one pop per cycle.

## Test plan
- Reset: assert rst mid-run with pending=3 and a compare in flight -> all outputs 0, in_ready=1, no pulse after release.
- Match: push 0x04030201, then res_e=0x03, res_f=0x07 -> match_pulse one cycle later, pass_count=1, pending=0.
- Mismatch: push 0x04030201, return res_e=0x03, res_f=0x06 -> mismatch_pulse, fail_count=1, first_fail_word=0x04030201, first_fail_got=0x0306; second mismatch leaves capture unchanged.
- Full/overflow: push 8 words, no results -> pending=8, in_ready=0; further in_valid -> overflow_err=1, pending stays 8; drain 8 correct results -> pass_count=8 in push order.
- Underflow: res_valid with pending=0 and simultaneous push of 0xFF00FF00 -> underflow_err=1, counts 0, pending=1.
- Streaming/wrap: 20 words with push+pop every cycle at pending=3 -> pending stays 3, 20 matches, pointers wrap; with CNT_W=2 pass_count saturates at 3.

Source files
------------

// File: rtl/logic_pipe_scoreboard.sv
// logic_pipe_scoreboard
// Receiving-end checker for the pipelined logic-operation datapath. Operand
// words issued to the producer are queued in an in-order FIFO. Each returned
// E/F result pops the oldest word and is registered into a compare stage. One
// cycle later a match or mismatch pulse is emitted, with saturating counters,
// first-failure capture and sticky overflow/underflow flags.
module logic_pipe_scoreboard #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [31:0]                in_word,
    output logic                       in_ready,
    input  logic                       res_valid,
    input  logic [7:0]                 res_e,
    input  logic [7:0]                 res_f,
    output logic                       match_pulse,
    output logic                       mismatch_pulse,
    output logic [CNT_W-1:0]           pass_count,
    output logic [CNT_W-1:0]           fail_count,
    output logic [31:0]                first_fail_word,
    output logic [15:0]                first_fail_got,
    output logic                       overflow_err,
    output logic                       underflow_err,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    FULL_LVL = PW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Expected {E,F} for one operand word: E = A | (B & C), F = (B & C) ^ (A | D).
    function automatic logic [15:0] calc_expected(input logic [31:0] word);
        logic [7:0] a_v, b_v, c_v, d_v, bc_v;
        a_v  = word[7:0];
        b_v  = word[15:8];
        c_v  = word[23:16];
        d_v  = word[31:24];
        bc_v = b_v & c_v;
        return {a_v | bc_v, bc_v ^ (a_v | d_v)};
    endfunction

    logic [31:0]      mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [PW-1:0]    count_r, count_next_s;
    logic             in_ready_r;
    logic             full_s, empty_s, push_s, pop_s;

    logic             cmp_valid_r;
    logic [31:0]      cmp_word_r;
    logic [15:0]      cmp_got_r;
    logic             cmp_ok_s;

    logic             match_r, mismatch_r, ovf_r, unf_r;
    logic [CNT_W-1:0] pass_r, fail_r;
    logic [31:0]      ff_word_r;
    logic [15:0]      ff_got_r;

    // Handshake decode and next FIFO occupancy from the current registered state.
    always_comb begin
        full_s       = (count_r == FULL_LVL);
        empty_s      = (count_r == {PW{1'b0}});
        push_s       = in_valid & ~full_s;
        pop_s        = res_valid & ~empty_s;
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + PW'(1);
            2'b01:   count_next_s = count_r - PW'(1);
            default: count_next_s = count_r;
        endcase
        if (cmp_valid_r) begin
            cmp_ok_s = (calc_expected(cmp_word_r) == cmp_got_r);
        end else begin
            cmp_ok_s = 1'b0;
        end
    end

    // FIFO storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_r[wr_ptr_r] <= in_word;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {PW{1'b0}};
            in_ready_r <= 1'b1;
        end else if (clear) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {PW{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s != FULL_LVL);
        end
    end

    // Compare stage: capture the popped head word together with the returned result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_valid_r <= 1'b0;
            cmp_word_r  <= 32'h0000_0000;
            cmp_got_r   <= 16'h0000;
        end else if (clear) begin
            cmp_valid_r <= 1'b0;
            cmp_word_r  <= 32'h0000_0000;
            cmp_got_r   <= 16'h0000;
        end else begin
            cmp_valid_r <= pop_s;
            cmp_word_r  <= mem_r[rd_ptr_r];
            cmp_got_r   <= {res_e, res_f};
        end
    end

    // Verdict stage: pulses, saturating counters, first-failure capture, sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_r    <= 1'b0;
            mismatch_r <= 1'b0;
            pass_r     <= {CNT_W{1'b0}};
            fail_r     <= {CNT_W{1'b0}};
            ff_word_r  <= 32'h0000_0000;
            ff_got_r   <= 16'h0000;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else if (clear) begin
            match_r    <= 1'b0;
            mismatch_r <= 1'b0;
            pass_r     <= {CNT_W{1'b0}};
            fail_r     <= {CNT_W{1'b0}};
            ff_word_r  <= 32'h0000_0000;
            ff_got_r   <= 16'h0000;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            match_r    <= cmp_valid_r & cmp_ok_s;
            mismatch_r <= cmp_valid_r & ~cmp_ok_s;
            if (cmp_valid_r && cmp_ok_s && (pass_r != CNT_MAX)) begin
                pass_r <= pass_r + CNT_W'(1);
            end
            if (cmp_valid_r && !cmp_ok_s && (fail_r != CNT_MAX)) begin
                fail_r <= fail_r + CNT_W'(1);
            end
            if (cmp_valid_r && !cmp_ok_s && (fail_r == {CNT_W{1'b0}})) begin
                ff_word_r <= cmp_word_r;
                ff_got_r  <= cmp_got_r;
            end
            ovf_r <= ovf_r | (in_valid & full_s);
            unf_r <= unf_r | (res_valid & empty_s);
        end
    end

    assign in_ready        = in_ready_r;
    assign pending         = count_r;
    assign match_pulse     = match_r;
    assign mismatch_pulse  = mismatch_r;
    assign pass_count      = pass_r;
    assign fail_count      = fail_r;
    assign first_fail_word = ff_word_r;
    assign first_fail_got  = ff_got_r;
    assign overflow_err    = ovf_r;
    assign underflow_err   = unf_r;

endmodule
